// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder slice.
//   mem_state_e : FSM state encoding (ST_IDLE=0, ST_WAIT=1, ST_DONE=2), 2 bits
//   WAIT_CNT_W  : width of the wait-state down-counter (supports 0..15 wait states)
package data_mem_responder_pkg;

  localparam int WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

endpackage

// File: rtl/data_mem_responder_if.sv
// CPU <-> data-memory bus.
//   mem_read / mem_write : request lines, held stable by the CPU while stall=1
//   addr / writedata     : byte address and store data
//   readdata             : load data, valid in DONE and held until the next load completes
//   stall                : PC hold line back to the CPU
//   busy                 : responder is in WAIT or DONE
//   state_dbg            : current FSM state, for observation only
//   misalign_err         : (MEM_MISALIGN_CHK_EN only) pulses for the DONE cycle of a misaligned access
// Handshake: a request is taken when the responder is idle and mem_read|mem_write is high;
// the CPU keeps the request stable while stall=1 and the access is committed at the clock
// edge that ends the cycle where stall first drops back to 0 (the DONE cycle).
interface data_mem_responder_if #(
  parameter int DWIDTH = 32
);
  import data_mem_responder_pkg::*;

  logic              mem_read;
  logic              mem_write;
  logic [DWIDTH-1:0] addr;
  logic [DWIDTH-1:0] writedata;
  logic [DWIDTH-1:0] readdata;
  logic              stall;
  logic              busy;
  mem_state_e        state_dbg;
`ifdef MEM_MISALIGN_CHK_EN
  logic              misalign_err;

  modport master (output mem_read, mem_write, addr, writedata,
                  input  readdata, stall, busy, state_dbg, misalign_err);
  modport slave  (input  mem_read, mem_write, addr, writedata,
                  output readdata, stall, busy, state_dbg, misalign_err);
`else
  modport master (output mem_read, mem_write, addr, writedata,
                  input  readdata, stall, busy, state_dbg);
  modport slave  (input  mem_read, mem_write, addr, writedata,
                  output readdata, stall, busy, state_dbg);
`endif

endinterface

// File: rtl/data_mem_responder_sp_ram.sv
// sp_ram: single-port synchronous RAM, one write and one registered read per clock.
//   clk, rst_n : clock, async active-low reset (clears only the read register, not the array)
//   we, re     : write / read enables
//   addr       : word index
//   wdata      : write data
//   rdata      : registered read data, holds its value when re=0
module sp_ram #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic [AWIDTH-1:0] addr,
  input  logic [DWIDTH-1:0] wdata,
  output logic [DWIDTH-1:0] rdata
);

  logic [DWIDTH-1:0] mem [2**AWIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: multicycle data-memory responder with a fixed number of wait states.
// The CPU is stalled for WAIT_CYCLES+1 cycles per access; the RAM is read/written on the
// edge that enters DONE, and stall is low in DONE so the CPU commits at the following edge.
//   clk    : system clock, rising edge
//   reset  : asynchronous, active-low
//   bus    : data_mem_responder_if slave modport (request, data, stall, busy, state_dbg)
// Optional feature macro MEM_MISALIGN_CHK_EN: misaligned accesses (addr[1:0]!=0) are timed
// normally but do not write RAM, loads return 0, and bus.misalign_err pulses in DONE.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DWIDTH      = 32,
  parameter int AWIDTH      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_responder_if.slave  bus
);

  localparam logic [WAIT_CNT_W-1:0] CNT_INIT =
    (WAIT_CYCLES == 0) ? '0 : WAIT_CNT_W'(WAIT_CYCLES - 1);

  mem_state_e              state_q, state_d;
  logic [WAIT_CNT_W-1:0]   count_q, count_d;
  logic                    req;
  logic                    commit;

  // Request latch, captured when the access is accepted in IDLE.
  logic                    lat_store;
  logic [AWIDTH-1:0]       lat_idx;
  logic [DWIDTH-1:0]       lat_wdata;

  // Access fields seen at the commit edge. With zero wait states the commit edge is the
  // acceptance edge itself, so the live request is used there instead of the latch.
  logic                    acc_store;
  logic [AWIDTH-1:0]       acc_idx;
  logic [DWIDTH-1:0]       acc_wdata;
  logic                    acc_mis;
  logic [DWIDTH-1:0]       ram_rdata;

  assign req = bus.mem_read | bus.mem_write;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    commit    = 1'b0;
    bus.stall = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          bus.stall = 1'b1;
          count_d   = CNT_INIT;
          if (WAIT_CYCLES == 0) begin
            state_d = ST_DONE;
            commit  = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        bus.stall = 1'b1;
        if (count_q == '0) begin
          state_d = ST_DONE;
          commit  = 1'b1;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.state_dbg = state_q;

  // Store wins when both request lines are high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_store <= 1'b0;
      lat_idx   <= '0;
      lat_wdata <= '0;
    end else if (state_q == ST_IDLE && req) begin
      lat_store <= bus.mem_write;
      lat_idx   <= bus.addr[AWIDTH+1:2];
      lat_wdata <= bus.writedata;
    end
  end

  assign acc_store = (state_q == ST_IDLE) ? bus.mem_write        : lat_store;
  assign acc_idx   = (state_q == ST_IDLE) ? bus.addr[AWIDTH+1:2] : lat_idx;
  assign acc_wdata = (state_q == ST_IDLE) ? bus.writedata        : lat_wdata;

`ifdef MEM_MISALIGN_CHK_EN
  logic lat_mis;
  logic load_zero_q;   // last completed load was misaligned, so readdata reads as 0

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                        lat_mis <= 1'b0;
    else if (state_q == ST_IDLE && req) lat_mis <= (bus.addr[1:0] != 2'b00);
  end

  assign acc_mis = (state_q == ST_IDLE) ? (bus.addr[1:0] != 2'b00) : lat_mis;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                      load_zero_q <= 1'b0;
    else if (commit && !acc_store)   load_zero_q <= acc_mis;
  end

  assign bus.readdata     = load_zero_q ? '0 : ram_rdata;
  assign bus.misalign_err = (state_q == ST_DONE) && lat_mis;

  wire unused_addr_bits = ^bus.addr[DWIDTH-1:AWIDTH+2];
`else
  assign acc_mis      = 1'b0;
  assign bus.readdata = ram_rdata;

  wire unused_addr_bits = ^{bus.addr[DWIDTH-1:AWIDTH+2], bus.addr[1:0]};
`endif

  sp_ram #(
    .DWIDTH (DWIDTH),
    .AWIDTH (AWIDTH)
  ) u_ram (
    .clk   (clk),
    .rst_n (reset),
    .we    (commit & acc_store & ~acc_mis),
    .re    (commit & ~acc_store),
    .addr  (acc_idx),
    .wdata (acc_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;
  import data_mem_responder_pkg::*;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int WC = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  data_mem_responder_if #(.DWIDTH(DW)) bus ();

  data_mem_responder #(
    .DWIDTH      (DW),
    .AWIDTH      (AW),
    .WAIT_CYCLES (WC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] model_mem [2**AW];
  logic [DW-1:0] model_rd;
  logic [DW-1:0] exp_q[$];
  logic          exp_err_q[$];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  // A DONE cycle is visible as busy=1 with stall=0.
  always @(negedge clk) begin
    logic [DW-1:0] e_rd;
    logic          e_err;
    if (reset === 1'b1) begin
      if (bus.busy === 1'b1 && bus.stall === 1'b0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e_rd  = exp_q.pop_front();
          e_err = exp_err_q.pop_front();
          check("readdata", bus.readdata, e_rd);
`ifdef MEM_MISALIGN_CHK_EN
          check("misalign_err", {31'd0, bus.misalign_err}, {31'd0, e_err});
`else
          if (e_err) check("model_misalign", 32'd1, 32'd0);
`endif
        end
      end
`ifdef MEM_MISALIGN_CHK_EN
      else if (bus.misalign_err !== 1'b0) begin
        check("misalign_err_idle", {31'd0, bus.misalign_err}, 32'd0);
      end
`endif
    end
  end

  // ---------------- driver ----------------
  // Called at #1 after a rising edge; returns at #1 after the commit edge with the
  // request still driven, so the caller either issues the next access back-to-back
  // or calls drop().
  task automatic issue(input bit rd, input bit wr, input logic [DW-1:0] a, input logic [DW-1:0] wd);
    logic [AW-1:0] idx;
    bit            mis;
    int            cyc;
    idx = a[AW+1:2];
`ifdef MEM_MISALIGN_CHK_EN
    mis = (a[1:0] != 2'b00);
`else
    mis = 1'b0;
`endif
    if (wr) begin
      if (!mis) model_mem[idx] = wd;
    end else if (rd) begin
      model_rd = mis ? '0 : model_mem[idx];
    end
    exp_q.push_back(model_rd);
    exp_err_q.push_back(mis);

    bus.mem_read  = rd;
    bus.mem_write = wr;
    bus.addr      = a;
    bus.writedata = wd;
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.stall === 1'b1) cyc++;
      else break;
    end
    check("stall_len", cyc, WC + 1);
    @(posedge clk);
    #1;
  endtask

  task automatic drop(input int idle_cycles);
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    for (int i = 0; i < idle_cycles; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Store that is cut off by reset while in WAIT: nothing is queued, nothing is written.
  task automatic aborted_store(input logic [DW-1:0] a, input logic [DW-1:0] wd);
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b1;
    bus.addr      = a;
    bus.writedata = wd;
    @(negedge clk);   // IDLE, accepted
    @(negedge clk);   // WAIT
    check("abort_stall_in_wait", {31'd0, bus.stall}, 32'd1);
    #1;
    reset         = 1'b0;
    bus.mem_write = 1'b0;
    #1;
    check("abort_stall", {31'd0, bus.stall}, 32'd0);
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_readdata", bus.readdata, 32'd0);
    model_rd = '0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main stimulus ----------------
  initial begin
    logic [DW-1:0] a;
    bit            rd, wr;

    reset         = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.addr      = '0;
    bus.writedata = '0;
    model_rd      = '0;
    #1;
    check("reset_readdata", bus.readdata, 32'd0);
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_stall", {31'd0, bus.stall}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Give every word a known value so random loads have a defined expectation.
    for (int w = 0; w < 2**AW; w++) issue(1'b0, 1'b1, 32'(w) << 2, $urandom);
    drop(1);

    // Store 0xDEADBEEF @0x10, then load it back after an idle gap.
    issue(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    drop(2);
    issue(1'b1, 1'b0, 32'h10, 32'h0);
    drop(1);

    // Back-to-back store/load to the same word, request present right after DONE.
    issue(1'b0, 1'b1, 32'h4, 32'hC0FFEE01);
    issue(1'b1, 1'b0, 32'h4, 32'h0);
    drop(1);

    // Read and write together behave as a store; readdata keeps the previous load value.
    issue(1'b1, 1'b1, 32'h8, 32'h12345678);
    issue(1'b1, 1'b0, 32'h8, 32'h0);
    drop(1);

    // Reset during WAIT of a store: the word keeps its old contents.
    aborted_store(32'h20, 32'hAAAA0000);
    issue(1'b1, 1'b0, 32'h20, 32'h0);
    drop(1);

    // Misaligned store, then aligned load of the same word.
    issue(1'b0, 1'b1, 32'h11, 32'h5A5A5A5A);
    drop(1);
    issue(1'b1, 1'b0, 32'h10, 32'h0);
    drop(1);
    // Misaligned load of a word holding non-zero data.
    issue(1'b1, 1'b0, 32'h12, 32'h0);
    drop(1);

    // Randomized mix: loads, stores, both, random upper/low address bits, random gaps.
    for (int n = 0; n < 250; n++) begin
      case ($urandom_range(0, 9))
        0:       begin rd = 1'b1; wr = 1'b1; end
        1,2,3,4: begin rd = 1'b0; wr = 1'b1; end
        default: begin rd = 1'b1; wr = 1'b0; end
      endcase
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      if ($urandom_range(0, 2) == 0) a[AW+1:2] = AW'($urandom_range(0, 3));
      issue(rd, wr, a, $urandom);
      if ($urandom_range(0, 1) == 0) drop($urandom_range(1, 3));
    end
    drop(3);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
